// File: rtl/noc_port_arbiter.sv
// Round-robin, packet-granular arbiter with a per-requester burst limit.
// It shares one NoC injection port through a single registered valid/ready output stage.
module noc_port_arbiter #(
  parameter int N_REQ     = 4,
  parameter int WIDTH_PKT = 36,
  parameter int BURST     = 2,
  parameter int ID_WIDTH  = $clog2(N_REQ)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ*WIDTH_PKT-1:0] i_packet_in,
  input  logic [N_REQ-1:0]           i_valid_in,
  output logic [N_REQ-1:0]           i_ready_out,
  output logic [WIDTH_PKT-1:0]       o_packet_out,
  output logic                       o_valid_out,
  input  logic                       o_ready_in,
  output logic [ID_WIDTH-1:0]        o_grant_id
);

  localparam int CNT_W = $clog2(BURST + 1);
  localparam logic [CNT_W-1:0]    BURST_C = CNT_W'(BURST);
  localparam logic [CNT_W-1:0]    CNT_ONE = CNT_W'(1);
  localparam logic [ID_WIDTH-1:0] PTR_RST = ID_WIDTH'(N_REQ - 1);

  logic [WIDTH_PKT-1:0] pkt_q, pkt_d;
  logic                 valid_q, valid_d;
  logic [ID_WIDTH-1:0]  gid_q, gid_d;
  logic [ID_WIDTH-1:0]  ptr_q, ptr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic [ID_WIDTH-1:0]  sel, idx;
  logic [WIDTH_PKT-1:0] sel_pkt;
  logic                 load_en, any_valid, others, stay, found, xfer;

  assign load_en   = !valid_q || o_ready_in;
  assign any_valid = |i_valid_in;
  assign xfer      = load_en && any_valid;
  assign sel_pkt   = i_packet_in[int'(sel)*WIDTH_PKT +: WIDTH_PKT];

  // cnt==0 only occurs after reset and means "no current owner", so the
  // reset pointer does not keep the port and the first search starts at 0.
  always_comb begin
    others = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (k != int'(ptr_q) && i_valid_in[k]) others = 1'b1;
    end
    stay  = i_valid_in[ptr_q] &&
            (((cnt_q != '0) && (cnt_q < BURST_C)) || !others);
    sel   = ptr_q;
    idx   = ptr_q;
    found = 1'b0;
    for (int off = 1; off <= N_REQ; off++) begin
      idx = ID_WIDTH'((int'(ptr_q) + off) % N_REQ);
      if (!found && i_valid_in[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
    if (stay) sel = ptr_q;
  end

  always_comb begin
    i_ready_out = '0;
    if (xfer) i_ready_out[sel] = 1'b1;
  end

  always_comb begin
    pkt_d   = pkt_q;
    valid_d = valid_q;
    gid_d   = gid_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    if (xfer) begin
      pkt_d   = sel_pkt;
      gid_d   = sel;
      valid_d = 1'b1;
      if (sel == ptr_q) begin
        if (cnt_q < BURST_C) cnt_d = cnt_q + CNT_ONE;
      end else begin
        ptr_d = sel;
        cnt_d = CNT_ONE;
      end
    end else if (o_ready_in) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_q   <= '0;
      valid_q <= 1'b0;
      gid_q   <= '0;
      ptr_q   <= PTR_RST;
      cnt_q   <= '0;
    end else begin
      pkt_q   <= pkt_d;
      valid_q <= valid_d;
      gid_q   <= gid_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_packet_out = pkt_q;
  assign o_valid_out  = valid_q;
  assign o_grant_id   = gid_q;

endmodule

// File: tb/tb_noc_port_arbiter.sv
// Directed and random checks of noc_port_arbiter against a handshake-driven scoreboard.
module tb_noc_port_arbiter;
  localparam int N = 4;
  localparam int W = 36;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N*W-1:0] i_packet_in = '0;
  logic [N-1:0]  i_valid_in = '0;
  logic [N-1:0]  i_ready_out;
  logic [W-1:0]  o_packet_out;
  logic          o_valid_out;
  logic          o_ready_in = 1'b1;
  logic [1:0]    o_grant_id;

  noc_port_arbiter #(.N_REQ(N), .WIDTH_PKT(W), .BURST(2)) dut (
    .clk(clk), .rst_n(rst_n), .i_packet_in(i_packet_in), .i_valid_in(i_valid_in),
    .i_ready_out(i_ready_out), .o_packet_out(o_packet_out), .o_valid_out(o_valid_out),
    .o_ready_in(o_ready_in), .o_grant_id(o_grant_id)
  );

  always #5 clk = ~clk;

  typedef struct { logic [W-1:0] pkt; logic [1:0] gid; } sb_t;
  sb_t sb[$];
  int  acc_log[$];
  int  gid_log[$];

  int n_cmp = 0;
  int n_err = 0;

  logic         req_valid [N];
  logic [W-1:0] req_pkt   [N];
  logic         refill    [N];
  int           seq       [N];
  int           wait_cnt  [N];
  logic         rdy = 1'b1;
  logic         rand_mode = 1'b0;
  logic         toggle_mode = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] new_pkt(input int k);
    seq[k]++;
    return {4'(k), 32'(seq[k])};
  endfunction

  task automatic drive();
    for (int k = 0; k < N; k++) begin
      i_valid_in[k]          = req_valid[k];
      i_packet_in[k*W +: W]  = req_pkt[k];
    end
    o_ready_in = rdy;
  endtask

  task automatic clear_reqs();
    for (int k = 0; k < N; k++) begin
      req_valid[k] = 1'b0;
      req_pkt[k]   = '0;
      refill[k]    = 1'b0;
      wait_cnt[k]  = 0;
    end
  endtask

  // One clock: settle, score the output and input handshakes, advance requesters.
  task automatic step();
    sb_t        e;
    logic [N-1:0] vin, rout;
    #1;
    vin  = i_valid_in;
    rout = i_ready_out;
    if (rst_n) begin
      chk("rdy_onehot", 64'($onehot0(rout)), 64'd1);
      chk("rdy_only_valid", 64'(rout & ~vin), 64'd0);
      if (o_valid_out && o_ready_in) begin
        gid_log.push_back(int'(o_grant_id));
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $error("FAIL sb_underflow: got=%0h expected=none", o_packet_out);
        end else begin
          e = sb.pop_front();
          chk("out_pkt", 64'(o_packet_out), 64'(e.pkt));
          chk("out_gid", 64'(o_grant_id), 64'(e.gid));
        end
      end
      for (int k = 0; k < N; k++) begin
        if (vin[k] && rout[k]) begin
          e.pkt = req_pkt[k];
          e.gid = 2'(k);
          sb.push_back(e);
          acc_log.push_back(k);
          if (rand_mode) begin
            chk("wait_bound", 64'(wait_cnt[k] <= 6), 64'd1);
            wait_cnt[k] = 0;
            for (int j = 0; j < N; j++) if (j != k && vin[j]) wait_cnt[j]++;
            req_valid[k] = ($urandom_range(0, 3) != 0);
            req_pkt[k]   = new_pkt(k);
          end else if (refill[k]) begin
            req_pkt[k] = new_pkt(k);
          end else begin
            req_valid[k] = 1'b0;
          end
        end
      end
    end
    if (rand_mode) begin
      for (int k = 0; k < N; k++) begin
        if (!vin[k] && !req_valid[k] && $urandom_range(0, 2) == 0) begin
          req_valid[k] = 1'b1;
          req_pkt[k]   = new_pkt(k);
          wait_cnt[k]  = 0;
        end
      end
      rdy = toggle_mode ? !rdy : 1'($urandom_range(0, 1));
    end
    @(posedge clk);
    @(negedge clk);
    drive();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_reqs();
    rdy = 1'b1;
    drive();
    sb.delete();
    acc_log.delete();
    gid_log.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int exp2 [10];
    int exp3 [8];
    int exp4 [6];
    int lim;
    exp2 = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
    exp3 = '{2, 2, 2, 2, 2, 2, 0, 2};
    exp4 = '{1, 3, 3, 0, 0, 1};
    for (int k = 0; k < N; k++) seq[k] = 0;

    // reset state and single-requester latency
    do_reset();
    #1;
    chk("rst_valid", 64'(o_valid_out), 64'd0);
    chk("rst_pkt", 64'(o_packet_out), 64'd0);
    chk("rst_gid", 64'(o_grant_id), 64'd0);
    req_valid[0] = 1'b1;
    req_pkt[0]   = 36'h0000000AA;
    drive();
    #1;
    chk("t1_ready", 64'(i_ready_out), 64'b0001);
    step();
    chk("t1_valid", 64'(o_valid_out), 64'd1);
    chk("t1_pkt", 64'(o_packet_out), 64'h0000000AA);
    chk("t1_gid", 64'(o_grant_id), 64'd0);
    step();
    chk("t1_idle", 64'(o_valid_out), 64'd0);

    // all valid, BURST=2: pairs in round-robin order without bubbles
    do_reset();
    for (int k = 0; k < N; k++) begin
      req_valid[k] = 1'b1;
      refill[k]    = 1'b1;
      req_pkt[k]   = new_pkt(k);
    end
    drive();
    for (int i = 0; i < 11; i++) step();
    chk("t2_count", 64'(gid_log.size()), 64'd10);
    for (int i = 0; i < 10 && i < gid_log.size(); i++)
      chk($sformatf("t2_gid%0d", i), 64'(gid_log[i]), 64'(exp2[i]));

    // lone requester 2 saturates, then requester 0 is taken next
    do_reset();
    req_valid[2] = 1'b1;
    refill[2]    = 1'b1;
    req_pkt[2]   = new_pkt(2);
    drive();
    for (int i = 0; i < 6; i++) step();
    req_valid[0] = 1'b1;
    req_pkt[0]   = new_pkt(0);
    drive();
    for (int i = 0; i < 2; i++) step();
    chk("t3_count", 64'(acc_log.size()), 64'd8);
    for (int i = 0; i < 8 && i < acc_log.size(); i++)
      chk($sformatf("t3_acc%0d", i), 64'(acc_log[i]), 64'(exp3[i]));

    // backpressure holds the output register and arbitration state
    do_reset();
    req_valid[1] = 1'b1;
    req_pkt[1]   = 36'h123456789;
    drive();
    step();
    rdy = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (k != 2) begin
        req_valid[k] = 1'b1;
        refill[k]    = 1'b1;
        req_pkt[k]   = new_pkt(k);
      end
    end
    drive();
    acc_log.delete();
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t4_hold_pkt", 64'(o_packet_out), 64'h123456789);
      chk("t4_hold_valid", 64'(o_valid_out), 64'd1);
      chk("t4_hold_ready", 64'(i_ready_out), 64'd0);
      step();
    end
    rdy = 1'b1;
    drive();
    for (int i = 0; i < 6; i++) step();
    chk("t4_count", 64'(acc_log.size()), 64'd6);
    for (int i = 0; i < 6 && i < acc_log.size(); i++)
      chk($sformatf("t4_acc%0d", i), 64'(acc_log[i]), 64'(exp4[i]));

    // asynchronous reset mid-burst
    for (int i = 0; i < 2; i++) step();
    chk("t5_pre_valid", 64'(o_valid_out), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_async_valid", 64'(o_valid_out), 64'd0);
    chk("t5_async_pkt", 64'(o_packet_out), 64'd0);
    chk("t5_async_gid", 64'(o_grant_id), 64'd0);
    sb.delete();
    clear_reqs();
    drive();
    @(negedge clk);
    rst_n = 1'b1;
    acc_log.delete();
    req_valid[1] = 1'b1; req_pkt[1] = new_pkt(1);
    req_valid[2] = 1'b1; req_pkt[2] = new_pkt(2);
    drive();
    step();
    chk("t5_first", 64'(acc_log.size() > 0 ? acc_log[0] : -1), 64'd1);
    for (int i = 0; i < 3; i++) step();

    // random traffic; the first stretch toggles router ready every cycle
    do_reset();
    rand_mode   = 1'b1;
    toggle_mode = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      if (i == 400) toggle_mode = 1'b0;
      step();
    end
    rand_mode = 1'b0;
    clear_reqs();
    rdy = 1'b1;
    drive();
    lim = 0;
    while (sb.size() > 0 && lim < 20) begin
      step();
      lim++;
    end
    chk("drain_empty", 64'(sb.size()), 64'd0);
    chk("drain_idle", 64'(o_valid_out), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
